// File: rtl/mirfak_fetch_unit.sv
// Instruction fetch stage with IF/ID pipeline register.
// Classic Wishbone instruction master; redirects from ID (branch/jump) and WB (trap/xret).
module mirfak_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  input  logic        ifid_enable_i,
  input  logic        ifid_clear_i,
  input  logic        id_bj_taken_i,
  input  logic [31:0] id_bj_target_i,
  input  logic        wb_exception_i,
  input  logic        wb_xret_i,
  input  logic [31:0] wb_target_i,
  output logic        if_ready_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instruction_o,
  output logic        id_valid_o,
  output logic        id_fetch_fault_o,
  output logic        id_misaligned_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        active_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic        buf_fault_q, buf_fault_d;
  logic        buf_mis_q, buf_mis_d;

  logic [31:0] id_pc_q, id_instr_q;
  logic        id_valid_q, id_fault_q, id_mis_q;

  logic        busy, done, redir, jump;
  logic [31:0] redir_tgt, jump_tgt;

  // active_q keeps the bus quiet during reset and the first cycle after it,
  // so a late ack from an aborted transfer can never complete a new request.
  assign busy        = active_q && (state_q != S_HOLD);
  assign done        = busy && (iwbm_ack_i || iwbm_err_i);
  assign redir       = wb_exception_i || wb_xret_i || id_bj_taken_i;
  assign redir_tgt   = (wb_exception_i || wb_xret_i) ? wb_target_i : id_bj_target_i;

  assign iwbm_cyc_o  = busy;
  assign iwbm_stb_o  = busy;
  assign iwbm_addr_o = {pc_q[31:2], 2'b00};
  assign if_ready_o  = (state_q == S_HOLD);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    buf_instr_d = buf_instr_q;
    buf_fault_d = buf_fault_q;
    buf_mis_d   = buf_mis_q;
    jump        = 1'b0;
    jump_tgt    = pc_q;

    case (state_q)
      S_REQ: begin
        if (redir && busy && !done) begin
          state_d = S_DRAIN;
          pend_d  = redir_tgt;
        end else if (redir) begin
          jump     = 1'b1;
          jump_tgt = redir_tgt;
        end else if (done) begin
          state_d     = S_HOLD;
          buf_instr_d = iwbm_err_i ? NOP : iwbm_dat_i;
          buf_fault_d = iwbm_err_i;
          buf_mis_d   = 1'b0;
        end
      end
      S_HOLD: begin
        if (redir) begin
          jump     = 1'b1;
          jump_tgt = redir_tgt;
        end else if (ifid_enable_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // A redirect arriving with the completing response supersedes the stored target.
        if (done) begin
          jump     = 1'b1;
          jump_tgt = redir ? redir_tgt : pend_q;
        end else if (redir) begin
          pend_d = redir_tgt;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (jump) begin
      pc_d = jump_tgt;
      if (jump_tgt[1:0] != 2'b00) begin
        state_d     = S_HOLD;
        buf_instr_d = NOP;
        buf_fault_d = 1'b0;
        buf_mis_d   = 1'b1;
      end else begin
        state_d = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_REQ;
      active_q <= 1'b0;
      pc_q     <= RESET_ADDR;
    end else begin
      state_q  <= state_d;
      active_q <= 1'b1;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    pend_q      <= pend_d;
    buf_instr_q <= buf_instr_d;
    buf_fault_q <= buf_fault_d;
    buf_mis_q   <= buf_mis_d;
  end

  // IF/ID register: clear beats enable; enable only takes effect with a buffered result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      id_fault_q <= 1'b0;
      id_mis_q   <= 1'b0;
    end else if (ifid_clear_i) begin
      id_pc_q    <= 32'h0;
      id_instr_q <= NOP;
      id_valid_q <= 1'b0;
      id_fault_q <= 1'b0;
      id_mis_q   <= 1'b0;
    end else if (ifid_enable_i && (state_q == S_HOLD)) begin
      id_pc_q    <= pc_q;
      id_instr_q <= buf_instr_q;
      id_valid_q <= 1'b1;
      id_fault_q <= buf_fault_q;
      id_mis_q   <= buf_mis_q;
    end
  end

  assign id_pc_o          = id_pc_q;
  assign id_instruction_o = id_instr_q;
  assign id_valid_o       = id_valid_q;
  assign id_fetch_fault_o = id_fault_q;
  assign id_misaligned_o  = id_mis_q;

endmodule

// File: tb/tb_mirfak_fetch_unit.sv
// Directed testbench for mirfak_fetch_unit; the bench plays the Wishbone slave and controller.
module tb_mirfak_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        cyc, stb;
  logic [31:0] dat;
  logic        ack, err;
  logic        en, clr;
  logic        bj;
  logic [31:0] bj_tgt;
  logic        exc, xret;
  logic [31:0] wb_tgt;
  logic        ready;
  logic [31:0] id_pc, id_instr;
  logic        id_valid, id_fault, id_mis;

  int pass_cnt = 0;
  int total_cnt = 0;

  mirfak_fetch_unit #(.RESET_ADDR(32'h8000_0000)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .iwbm_addr_o(addr), .iwbm_cyc_o(cyc), .iwbm_stb_o(stb),
    .iwbm_dat_i(dat), .iwbm_ack_i(ack), .iwbm_err_i(err),
    .ifid_enable_i(en), .ifid_clear_i(clr),
    .id_bj_taken_i(bj), .id_bj_target_i(bj_tgt),
    .wb_exception_i(exc), .wb_xret_i(xret), .wb_target_i(wb_tgt),
    .if_ready_o(ready),
    .id_pc_o(id_pc), .id_instruction_o(id_instr), .id_valid_o(id_valid),
    .id_fetch_fault_o(id_fault), .id_misaligned_o(id_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total_cnt++;
    if (cyc !== 1'b0) $display("FAIL reset_cyc got %0b want 0", cyc); else pass_cnt++;
    total_cnt++;
    if (id_instr !== 32'h0000_0013 || id_pc !== 32'h0 || id_valid !== 1'b0 || id_fault !== 1'b0 || id_mis !== 1'b0)
      $display("FAIL reset_id got instr %h pc %h v%0b f%0b m%0b want 00000013 00000000 0 0 0",
               id_instr, id_pc, id_valid, id_fault, id_mis);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
    total_cnt++;
    if (cyc !== 1'b1 || stb !== 1'b1 || addr !== 32'h8000_0000)
      $display("FAIL first_req got cyc%0b stb%0b addr %h want 1 1 80000000", cyc, stb, addr);
    else pass_cnt++;
    ack = 1'b1; dat = 32'h0010_0093;
    step();
    ack = 1'b0;
    total_cnt++;
    if (ready !== 1'b1 || cyc !== 1'b0)
      $display("FAIL first_ready got ready%0b cyc%0b want 1 0", ready, cyc);
    else pass_cnt++;
    en = 1'b1;
    step();
    en = 1'b0;
    total_cnt++;
    if (id_pc !== 32'h8000_0000 || id_valid !== 1'b1 || id_instr !== 32'h0010_0093)
      $display("FAIL first_id got pc %h v%0b instr %h want 80000000 1 00100093", id_pc, id_valid, id_instr);
    else pass_cnt++;
    total_cnt++;
    if (addr !== 32'h8000_0004 || cyc !== 1'b1)
      $display("FAIL next_addr got %h cyc%0b want 80000004 1", addr, cyc);
    else pass_cnt++;
  endtask

  task automatic test_hold_stall();
    ack = 1'b1; dat = 32'h0020_0113;
    step();
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (cyc !== 1'b0 || ready !== 1'b1 || addr !== 32'h8000_0004 || id_pc !== 32'h8000_0000)
        $display("FAIL hold_%0d got cyc%0b ready%0b addr %h idpc %h want 0 1 80000004 80000000",
                 i, cyc, ready, addr, id_pc);
      else pass_cnt++;
    end
    en = 1'b1;
    step();
    en = 1'b0;
    total_cnt++;
    if (id_pc !== 32'h8000_0004 || id_instr !== 32'h0020_0113)
      $display("FAIL hold_release got pc %h instr %h want 80000004 00200113", id_pc, id_instr);
    else pass_cnt++;
  endtask

  task automatic test_drain();
    bj = 1'b1; bj_tgt = 32'h8000_0100;
    step();
    bj = 1'b0;
    total_cnt++;
    if (cyc !== 1'b1 || addr !== 32'h8000_0008 || ready !== 1'b0)
      $display("FAIL drain_enter got cyc%0b addr %h ready%0b want 1 80000008 0", cyc, addr, ready);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (cyc !== 1'b1 || addr !== 32'h8000_0008)
        $display("FAIL drain_stable_%0d got cyc%0b addr %h want 1 80000008", i, cyc, addr);
      else pass_cnt++;
    end
    ack = 1'b1; dat = 32'hDEAD_BEEF;
    step();
    ack = 1'b0;
    total_cnt++;
    if (addr !== 32'h8000_0100 || cyc !== 1'b1 || ready !== 1'b0 || id_pc !== 32'h8000_0004)
      $display("FAIL drain_redirect got addr %h cyc%0b ready%0b idpc %h want 80000100 1 0 80000004",
               addr, cyc, ready, id_pc);
    else pass_cnt++;
    ack = 1'b1; dat = 32'h0000_0011;
    step();
    ack = 1'b0;
    en = 1'b1;
    step();
    en = 1'b0;
    total_cnt++;
    if (id_pc !== 32'h8000_0100 || id_instr !== 32'h0000_0011)
      $display("FAIL drain_data got pc %h instr %h want 80000100 00000011", id_pc, id_instr);
    else pass_cnt++;
  endtask

  task automatic test_priority();
    exc = 1'b1; wb_tgt = 32'h8000_0004;
    bj = 1'b1; bj_tgt = 32'h8000_0200;
    ack = 1'b1; dat = 32'h0000_0033;
    step();
    exc = 1'b0; bj = 1'b0; ack = 1'b0;
    total_cnt++;
    if (addr !== 32'h8000_0004 || cyc !== 1'b1 || id_pc !== 32'h8000_0100)
      $display("FAIL wb_priority got addr %h cyc%0b idpc %h want 80000004 1 80000100", addr, cyc, id_pc);
    else pass_cnt++;
  endtask

  task automatic test_fetch_err();
    err = 1'b1; dat = 32'h1234_5678;
    step();
    err = 1'b0;
    total_cnt++;
    if (ready !== 1'b1 || cyc !== 1'b0)
      $display("FAIL err_ready got ready%0b cyc%0b want 1 0", ready, cyc);
    else pass_cnt++;
    en = 1'b1;
    step();
    en = 1'b0;
    total_cnt++;
    if (id_valid !== 1'b1 || id_fault !== 1'b1 || id_instr !== 32'h0000_0013 ||
        id_pc !== 32'h8000_0004 || id_mis !== 1'b0)
      $display("FAIL err_id got v%0b f%0b instr %h pc %h m%0b want 1 1 00000013 80000004 0",
               id_valid, id_fault, id_instr, id_pc, id_mis);
    else pass_cnt++;
  endtask

  task automatic test_misaligned();
    ack = 1'b1; dat = 32'h0000_0044;
    bj = 1'b1; bj_tgt = 32'h8000_0102;
    step();
    ack = 1'b0; bj = 1'b0;
    total_cnt++;
    if (cyc !== 1'b0 || ready !== 1'b1)
      $display("FAIL mis_hold got cyc%0b ready%0b want 0 1", cyc, ready);
    else pass_cnt++;
    en = 1'b1;
    step();
    en = 1'b0;
    total_cnt++;
    if (id_mis !== 1'b1 || id_pc !== 32'h8000_0102 || id_valid !== 1'b1 ||
        id_fault !== 1'b0 || id_instr !== 32'h0000_0013)
      $display("FAIL mis_id got m%0b pc %h v%0b f%0b instr %h want 1 80000102 1 0 00000013",
               id_mis, id_pc, id_valid, id_fault, id_instr);
    else pass_cnt++;
    total_cnt++;
    if (addr !== 32'h8000_0104 || cyc !== 1'b1)
      $display("FAIL mis_next_addr got %h cyc%0b want 80000104 1", addr, cyc);
    else pass_cnt++;
  endtask

  task automatic test_clear_wins();
    ack = 1'b1; dat = 32'h0000_0055;
    step();
    ack = 1'b0;
    clr = 1'b1; en = 1'b1;
    step();
    clr = 1'b0; en = 1'b0;
    total_cnt++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0000_0013 || id_mis !== 1'b0)
      $display("FAIL clear_wins got v%0b pc %h instr %h m%0b want 0 00000000 00000013 0",
               id_valid, id_pc, id_instr, id_mis);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    total_cnt++;
    if (cyc !== 1'b1)
      $display("FAIL mid_pre_cyc got %0b want 1", cyc);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (cyc !== 1'b0 || stb !== 1'b0)
      $display("FAIL mid_async_cyc got cyc%0b stb%0b want 0 0", cyc, stb);
    else pass_cnt++;
    ack = 1'b1; dat = 32'h0000_0066;
    step();
    rst_n = 1'b1;
    step();
    ack = 1'b0;
    total_cnt++;
    if (cyc !== 1'b1 || addr !== 32'h8000_0000 || ready !== 1'b0)
      $display("FAIL mid_restart got cyc%0b addr %h ready%0b want 1 80000000 0", cyc, addr, ready);
    else pass_cnt++;
    ack = 1'b1; dat = 32'h0000_0077;
    step();
    ack = 1'b0;
    en = 1'b1;
    step();
    en = 1'b0;
    total_cnt++;
    if (id_pc !== 32'h8000_0000 || id_instr !== 32'h0000_0077 || id_valid !== 1'b1)
      $display("FAIL mid_first_id got pc %h instr %h v%0b want 80000000 00000077 1", id_pc, id_instr, id_valid);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; dat = 32'h0; ack = 1'b0; err = 1'b0;
    en = 1'b0; clr = 1'b0; bj = 1'b0; bj_tgt = 32'h0;
    exc = 1'b0; xret = 1'b0; wb_tgt = 32'h0;
    test_reset();
    test_hold_stall();
    test_drain();
    test_priority();
    test_fetch_err();
    test_misaligned();
    test_clear_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
